// File: rtl/sisc_pkg.sv
// Shared SISC definitions: datapath widths and the instruction-memory loader state encoding.
package sisc_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned IM_ADDR_W      = 16;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        StLenHi,
        StLenLo,
        StData,
        StChk,
        StDone,
        StErr
    } loader_state_e;

endpackage

// File: rtl/im_loader_pack.sv
// Big-endian byte-to-word packer for the instruction-memory loader.
module im_loader_pack
    import sisc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_f,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word_next,
    output logic              word_done
);

    logic [WORD_W-1:0] word_q;
    logic [1:0]        idx_q;

    // Earlier bytes move toward the MSB, so the first byte of a word ends up in [31:24].
    assign word_next = {word_q[WORD_W-BYTE_W-1:0], byte_in};
    assign word_done = shift_en && (idx_q == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (shift_en) begin
            word_q <= word_next;
            idx_q  <= idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/im_loader.sv
// Boot-time instruction-memory writer: length-prefixed byte stream in, checksummed word writes out;
// holds the processor in reset until a load completes cleanly.
module im_loader
    import sisc_pkg::*;
#(
    parameter logic [IM_ADDR_W-1:0] BASE_ADDR = 16'h0000,
    parameter logic [15:0]          MAX_WORDS = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 rst_f,
    input  logic                 in_valid,
    input  logic [BYTE_W-1:0]    in_data,
    output logic                 in_ready,
    output logic                 im_we,
    output logic [IM_ADDR_W-1:0] im_addr,
    output logic [WORD_W-1:0]    im_wdata,
    output logic                 cpu_rst_f,
    output logic                 done,
    output logic                 err
);

    loader_state_e        state_q, state_d;
    logic                 in_ready_q, in_ready_d;
    logic [15:0]          len_q, len_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [BYTE_W-1:0]    csum_q, csum_d;
    logic                 im_we_q, im_we_d;
    logic [IM_ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [WORD_W-1:0]    im_wdata_q, im_wdata_d;

    logic              fire;
    logic              shift_en;
    logic [15:0]       len_full;
    logic [WORD_W-1:0] word_next;
    logic              word_done;

    assign fire     = in_valid && in_ready_q;
    assign shift_en = fire && (state_q == StData);
    assign len_full = {len_q[15:8], in_data};

    im_loader_pack u_pack (
        .clk       (clk),
        .rst_f     (rst_f),
        .shift_en  (shift_en),
        .byte_in   (in_data),
        .word_next (word_next),
        .word_done (word_done)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        csum_d     = csum_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;

        if (fire) begin
            unique case (state_q)
                StLenHi: begin
                    len_d[15:8] = in_data;
                    state_d     = StLenLo;
                end
                StLenLo: begin
                    len_d[7:0] = in_data;
                    if (len_full > MAX_WORDS) begin
                        state_d = StErr;
                    end else if (len_full == 16'd0) begin
                        state_d = StChk;
                    end else begin
                        state_d = StData;
                    end
                end
                StData: begin
                    csum_d = csum_q ^ in_data;
                    if (word_done) begin
                        im_we_d    = 1'b1;
                        im_wdata_d = word_next;
                        im_addr_d  = BASE_ADDR + cnt_q;
                        cnt_d      = cnt_q + 16'd1;
                        if (cnt_q == len_q - 16'd1) begin
                            state_d = StChk;
                        end
                    end
                end
                StChk: begin
                    state_d = (in_data == csum_q) ? StDone : StErr;
                end
                default: ;
            endcase
        end

        // Registered so in_ready stays low through reset and drops with the terminal state.
        in_ready_d = (state_d == StLenHi) || (state_d == StLenLo) ||
                     (state_d == StData)  || (state_d == StChk);
    end

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state_q    <= StLenHi;
            in_ready_q <= 1'b0;
            len_q      <= '0;
            cnt_q      <= '0;
            csum_q     <= '0;
            im_we_q    <= 1'b0;
            im_addr_q  <= BASE_ADDR;
            im_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            csum_q     <= csum_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign im_we     = im_we_q;
    assign im_addr   = im_addr_q;
    assign im_wdata  = im_wdata_q;
    assign done      = (state_q == StDone);
    assign err       = (state_q == StErr);
    assign cpu_rst_f = (state_q == StDone);

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: two instances (base 0 / max 4 words, base FFFF / default max).
module tb_im_loader;

    logic        clk;
    logic        rst_f     [2];
    logic        in_valid  [2];
    logic [7:0]  in_data   [2];
    logic        in_ready  [2];
    logic        im_we     [2];
    logic [15:0] im_addr   [2];
    logic [31:0] im_wdata  [2];
    logic        cpu_rst_f [2];
    logic        done      [2];
    logic        err       [2];

    logic [47:0] exp_q0 [$];
    logic [47:0] exp_q1 [$];

    int checks = 0;
    int errors = 0;

    im_loader #(
        .BASE_ADDR (16'h0000),
        .MAX_WORDS (16'd4)
    ) dut0 (
        .clk       (clk),
        .rst_f     (rst_f[0]),
        .in_valid  (in_valid[0]),
        .in_data   (in_data[0]),
        .in_ready  (in_ready[0]),
        .im_we     (im_we[0]),
        .im_addr   (im_addr[0]),
        .im_wdata  (im_wdata[0]),
        .cpu_rst_f (cpu_rst_f[0]),
        .done      (done[0]),
        .err       (err[0])
    );

    im_loader #(
        .BASE_ADDR (16'hFFFF)
    ) dut1 (
        .clk       (clk),
        .rst_f     (rst_f[1]),
        .in_valid  (in_valid[1]),
        .in_data   (in_data[1]),
        .in_ready  (in_ready[1]),
        .im_we     (im_we[1]),
        .im_addr   (im_addr[1]),
        .im_wdata  (im_wdata[1]),
        .cpu_rst_f (cpu_rst_f[1]),
        .done      (done[1]),
        .err       (err[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitors: every im_we must match the next expected (addr, data) pair.
    always @(negedge clk) begin
        if (im_we[0] === 1'b1) begin
            checks++;
            if (exp_q0.size() == 0) begin
                errors++;
                $display("FAIL dut0_write: unexpected write addr %h data %h", im_addr[0], im_wdata[0]);
            end else begin
                logic [47:0] e;
                e = exp_q0.pop_front();
                if ({im_addr[0], im_wdata[0]} !== e) begin
                    errors++;
                    $display("FAIL dut0_write: got %h/%h expected %h/%h",
                             im_addr[0], im_wdata[0], e[47:32], e[31:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (im_we[1] === 1'b1) begin
            checks++;
            if (exp_q1.size() == 0) begin
                errors++;
                $display("FAIL dut1_write: unexpected write addr %h data %h", im_addr[1], im_wdata[1]);
            end else begin
                logic [47:0] e;
                e = exp_q1.pop_front();
                if ({im_addr[1], im_wdata[1]} !== e) begin
                    errors++;
                    $display("FAIL dut1_write: got %h/%h expected %h/%h",
                             im_addr[1], im_wdata[1], e[47:32], e[31:0]);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge following the handshake edge.
    task automatic send(input int i, input logic [7:0] b);
        int t;
        t = 0;
        in_valid[i] = 1'b1;
        in_data[i]  = b;
        while (in_ready[i] !== 1'b1 && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (t >= 64) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: dut%0d byte %h got in_ready=0 required 1", i, b);
        end
        @(negedge clk);
        in_valid[i] = 1'b0;
    endtask

    task automatic send_bytes(input int i, input logic [7:0] bs [$], input bit throttle);
        foreach (bs[k]) begin
            if (throttle) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            send(i, bs[k]);
        end
    endtask

    task automatic push_exp(input int i, input logic [15:0] a, input logic [31:0] d);
        if (i == 0) exp_q0.push_back({a, d});
        else        exp_q1.push_back({a, d});
    endtask

    task automatic do_reset(input int i, input logic [15:0] base);
        rst_f[i]    = 1'b0;
        in_valid[i] = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready[i]), 32'd0);
        check("rst_im_we", 32'(im_we[i]), 32'd0);
        check("rst_im_addr", 32'(im_addr[i]), 32'(base));
        check("rst_im_wdata", im_wdata[i], 32'd0);
        check("rst_done_err_cpu", {29'd0, done[i], err[i], cpu_rst_f[i]}, 32'd0);
        rst_f[i] = 1'b1;
        @(negedge clk);
        check("rst_release_in_ready", 32'(in_ready[i]), 32'd1);
    endtask

    task automatic check_status(input string name, input int i, input logic d, input logic e,
                                input logic c, input logic r);
        check(name, {28'd0, done[i], err[i], cpu_rst_f[i], in_ready[i]}, {28'd0, d, e, c, r});
    endtask

    initial begin
        logic [7:0] v [$];
        for (int i = 0; i < 2; i++) begin
            rst_f[i]    = 1'b0;
            in_valid[i] = 1'b0;
            in_data[i]  = 8'h00;
        end
        @(negedge clk);
        do_reset(0, 16'h0000);
        do_reset(1, 16'hFFFF);

        // Normal load, continuous valid; checksum 08 ^ 22 = 2A.
        push_exp(0, 16'h0000, 32'h12345678);
        push_exp(0, 16'h0001, 32'hDEADBEEF);
        v = {8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78};
        send_bytes(0, v, 1'b0);
        check("write_latency", 32'(im_we[0]), 32'd1);
        v = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h2A};
        send_bytes(0, v, 1'b0);
        check_status("normal_done", 0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Empty image, good then bad checksum.
        do_reset(0, 16'h0000);
        v = {8'h00, 8'h00, 8'h00};
        send_bytes(0, v, 1'b0);
        check_status("empty_done", 0, 1'b1, 1'b0, 1'b1, 1'b0);
        do_reset(0, 16'h0000);
        v = {8'h00, 8'h00, 8'h01};
        send_bytes(0, v, 1'b0);
        check_status("empty_badsum", 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Checksum mismatch: writes still happen.
        do_reset(0, 16'h0000);
        push_exp(0, 16'h0000, 32'h12345678);
        push_exp(0, 16'h0001, 32'hDEADBEEF);
        v = {8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h2B};
        send_bytes(0, v, 1'b0);
        check_status("badsum_err", 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Over-length: 5 > MAX_WORDS=4.
        do_reset(0, 16'h0000);
        v = {8'h00, 8'h05};
        send_bytes(0, v, 1'b0);
        check_status("overlen_err", 0, 1'b0, 1'b1, 1'b0, 1'b0);
        in_valid[0] = 1'b1;
        in_data[0]  = 8'h11;
        repeat (6) @(negedge clk);
        check_status("overlen_stuck", 0, 1'b0, 1'b1, 1'b0, 1'b0);
        in_valid[0] = 1'b0;

        // Reset after 6 data bytes: word 0 written, partial word 1 discarded.
        do_reset(0, 16'h0000);
        push_exp(0, 16'h0000, 32'h12345678);
        v = {8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD};
        send_bytes(0, v, 1'b0);
        do_reset(0, 16'h0000);
        push_exp(0, 16'h0000, 32'h12345678);
        push_exp(0, 16'h0001, 32'hDEADBEEF);
        v = {8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h2A};
        send_bytes(0, v, 1'b0);
        check_status("reload_done", 0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Throttled source with address wrap on base FFFF.
        push_exp(1, 16'hFFFF, 32'h12345678);
        push_exp(1, 16'h0000, 32'hDEADBEEF);
        v = {8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h2A};
        send_bytes(1, v, 1'b1);
        check_status("wrap_done", 1, 1'b1, 1'b0, 1'b1, 1'b0);

        repeat (4) @(negedge clk);
        check("dut0_writes_outstanding", 32'(exp_q0.size()), 32'd0);
        check("dut1_writes_outstanding", 32'(exp_q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
